// File: rtl/multdiv_issue_ctrl.sv
// multdiv_issue_ctrl: issue/stall/writeback sequencer in front of the multi-cycle mult/div unit.
// Optional `define MULTDIV_ZERO_BYPASS_EN completes trivial zero-operand requests without the unit.
module multdiv_issue_ctrl #(
   parameter int TIMEOUT_CYCLES = 40,
   parameter int RD_W           = 5
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_is_div,
   input  logic [31:0]     req_opA,
   input  logic [31:0]     req_opB,
   input  logic [RD_W-1:0] req_rd,
   input  logic            flush,
   output logic [31:0]     md_operandA,
   output logic [31:0]     md_operandB,
   output logic            md_ctrl_MULT,
   output logic            md_ctrl_DIV,
   input  logic [31:0]     md_result,
   input  logic            md_exception,
   input  logic            md_resultRDY,
   output logic            wb_valid,
   input  logic            wb_ready,
   output logic [RD_W-1:0] wb_rd,
   output logic [31:0]     wb_data,
   output logic            wb_exception
);
   typedef enum logic [2:0] {IDLE, ISSUE, BUSY, DONE, DRAIN} state_t;
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   state_t            state_q, state_d;
   logic [31:0]       opa_q, opa_d, opb_q, opb_d, wb_data_q, wb_data_d;
   logic              is_div_q, is_div_d, wb_exc_q, wb_exc_d;
   logic [RD_W-1:0]   rd_q, rd_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic              wd_exp, byp, byp_exc;

   assign wd_exp = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

`ifdef MULTDIV_ZERO_BYPASS_EN
   // Any zero operand makes the answer 0; only a zero divisor flags an exception.
   assign byp     = (req_opA == 32'h0) || (req_opB == 32'h0);
   assign byp_exc = req_is_div && (req_opB == 32'h0);
`else
   assign byp     = 1'b0;
   assign byp_exc = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      is_div_d  = is_div_q;
      rd_d      = rd_q;
      wb_data_d = wb_data_q;
      wb_exc_d  = wb_exc_q;
      wd_d      = wd_q;
      case (state_q)
         IDLE: if (req_valid && !flush) begin
            opa_d    = req_opA;
            opb_d    = req_opB;
            is_div_d = req_is_div;
            rd_d     = req_rd;
            state_d  = byp ? DONE : ISSUE;
            if (byp) begin
               wb_data_d = 32'h0;
               wb_exc_d  = byp_exc;
            end
         end
         ISSUE: begin
            wd_d    = '0;
            state_d = flush ? DRAIN : BUSY;
         end
         BUSY: begin
            wd_d = wd_q + WD_W'(1);
            // A flush coinciding with the result discards it outright.
            if (flush) state_d = md_resultRDY ? IDLE : DRAIN;
            else if (md_resultRDY) begin
               wb_data_d = md_result;
               wb_exc_d  = md_exception;
               state_d   = DONE;
            end else if (wd_exp) begin
               wb_data_d = 32'h0;
               wb_exc_d  = 1'b1;
               state_d   = DONE;
            end
         end
         DONE: if (wb_ready || flush) state_d = IDLE;
         DRAIN: begin
            wd_d = wd_q + WD_W'(1);
            if (md_resultRDY || wd_exp) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         opa_q     <= 32'h0;
         opb_q     <= 32'h0;
         is_div_q  <= 1'b0;
         rd_q      <= '0;
         wb_data_q <= 32'h0;
         wb_exc_q  <= 1'b0;
         wd_q      <= '0;
      end else begin
         state_q   <= state_d;
         opa_q     <= opa_d;
         opb_q     <= opb_d;
         is_div_q  <= is_div_d;
         rd_q      <= rd_d;
         wb_data_q <= wb_data_d;
         wb_exc_q  <= wb_exc_d;
         wd_q      <= wd_d;
      end
   end

   assign req_ready    = (state_q == IDLE);
   assign md_operandA  = opa_q;
   assign md_operandB  = opb_q;
   assign md_ctrl_MULT = (state_q == ISSUE) && !is_div_q;
   assign md_ctrl_DIV  = (state_q == ISSUE) && is_div_q;
   assign wb_valid     = (state_q == DONE);
   assign wb_rd        = rd_q;
   assign wb_data      = wb_data_q;
   assign wb_exception = wb_exc_q;
endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// tb_multdiv_issue_ctrl: scoreboard bench with a behavioural 32-cycle mult/div unit stub.
module tb_multdiv_issue_ctrl;
   localparam int TO = 40;

   logic        clock = 1'b0, reset_n = 1'b0;
   logic        req_valid = 1'b0, req_is_div = 1'b0, flush = 1'b0, wb_ready = 1'b1;
   logic [31:0] req_opA = 32'h0, req_opB = 32'h0;
   logic [4:0]  req_rd = 5'h0;
   logic        req_ready, md_ctrl_MULT, md_ctrl_DIV, wb_valid, wb_exception;
   logic [31:0] md_operandA, md_operandB, wb_data;
   logic [31:0] md_result = 32'h0;
   logic        md_exception = 1'b0, md_resultRDY = 1'b0;
   logic [4:0]  wb_rd;

   always #5 clock = ~clock;

   multdiv_issue_ctrl #(.TIMEOUT_CYCLES(TO), .RD_W(5)) dut (
      .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_is_div(req_is_div), .req_opA(req_opA), .req_opB(req_opB), .req_rd(req_rd),
      .flush(flush), .md_operandA(md_operandA), .md_operandB(md_operandB),
      .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV), .md_result(md_result),
      .md_exception(md_exception), .md_resultRDY(md_resultRDY), .wb_valid(wb_valid),
      .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data), .wb_exception(wb_exception)
   );

   typedef struct packed {logic [4:0] rd; logic exc; logic [31:0] data;} exp_t;
   exp_t sb[$];
   int   n_tests = 0, n_fail = 0, n_mul = 0, n_div = 0, n_consec = 0, rdy_hi = 0;
   logic prev_pulse = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [32:0] md_model(input logic is_div, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      if (is_div) return (b == 32'h0) ? {1'b1, 32'h0} : {1'b0, 32'($signed(a) / $signed(b))};
      p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      return {p != {{32{p[31]}}, p[31:0]}, p[31:0]};
   endfunction

   // Unit stub: no reset, result pulse 32 cycles after the start pulse.
   logic        stub_dead = 1'b0, u_busy = 1'b0, u_div = 1'b0;
   int          u_cnt = 0;
   logic [31:0] u_a = 32'h0, u_b = 32'h0;
   always @(posedge clock) begin
      md_resultRDY <= 1'b0;
      if (md_ctrl_MULT || md_ctrl_DIV) begin
         u_busy <= 1'b1; u_cnt <= 30; u_div <= md_ctrl_DIV; u_a <= md_operandA; u_b <= md_operandB;
      end else if (u_busy) begin
         if (u_cnt == 0) begin
            u_busy <= 1'b0;
            if (!stub_dead) begin
               md_resultRDY <= 1'b1;
               {md_exception, md_result} <= md_model(u_div, u_a, u_b);
            end
         end else u_cnt <= u_cnt - 1;
      end
   end

   always @(negedge clock) begin
      if (md_ctrl_MULT) n_mul++;
      if (md_ctrl_DIV) n_div++;
      if ((md_ctrl_MULT || md_ctrl_DIV) && prev_pulse) n_consec++;
      prev_pulse = md_ctrl_MULT || md_ctrl_DIV;
   end

   task automatic do_req(input logic d, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      req_valid = 1'b1; req_is_div = d; req_opA = a; req_opB = b; req_rd = rd;
      for (int i = 0; i < 200 && !req_ready; i++) @(negedge clock);
      if (!req_ready) check("req_accept", 0, 1);
      @(negedge clock);
      req_valid = 1'b0;
   endtask

   task automatic wait_wb(output int lat);
      exp_t e;
      lat = -1;
      for (int i = 0; i < 200; i++) begin
         if (wb_valid && lat < 0) lat = i;
         if (wb_valid && wb_ready) begin
            if (sb.size() == 0) check("wb_spurious", 1, 0);
            else begin
               e = sb.pop_front();
               check("wb_data", wb_data, e.data);
               check("wb_rd", wb_rd, e.rd);
               check("wb_exc", wb_exception, e.exc);
            end
            @(negedge clock);
            return;
         end
         if (req_ready) rdy_hi++;
         @(negedge clock);
      end
      check("wb_timeout", 0, 1);
      sb.delete();
   endtask

   task automatic run_op(input logic d, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] ed, input logic ee, output int lat);
      sb.push_back('{rd: rd, exc: ee, data: ed});
      do_req(d, a, b, rd);
      wait_wb(lat);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      int lat, m0, d0, cnt;
      logic [32:0] r;
      logic [31:0] a, b;
      logic        d;
      repeat (2) @(negedge clock);
      check("rst_req_ready", req_ready, 1);
      check("rst_wb_valid", wb_valid, 0);
      check("rst_ctrl", {md_ctrl_MULT, md_ctrl_DIV}, 0);
      check("rst_wb_data", wb_data, 0);
      check("rst_wb_rd", wb_rd, 0);
      check("rst_wb_exc", wb_exception, 0);
      check("rst_opA", md_operandA, 0);
      reset_n = 1'b1;
      @(negedge clock);

      rdy_hi = 0; m0 = n_mul;
      run_op(0, 32'h7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 1'b0, lat);
      check("mul_pulses", n_mul - m0, 1);
      check("mul_latency", lat, 33);
      check("mul_ready_low", rdy_hi, 0);

      d0 = n_div;
      run_op(1, 32'hFFFFFF9C, 32'h7, 5'd6, 32'hFFFFFFF2, 1'b0, lat);
      check("div_pulses", n_div - d0, 1);

      run_op(0, 32'h00010000, 32'h00010000, 5'd8, 32'h0, 1'b1, lat);

      d0 = n_div;
      run_op(1, 32'h5, 32'h0, 5'd9, 32'h0, 1'b1, lat);
`ifdef MULTDIV_ZERO_BYPASS_EN
      check("div0_no_pulse", n_div - d0, 0);
      check("div0_bypass_lat", lat, 0);
`else
      check("div0_pulse", n_div - d0, 1);
`endif

      for (int k = 0; k < 4; k++) begin
         d = 1'($urandom_range(0, 1));
         a = 32'($urandom_range(0, 2000)) - 32'd1000;
         b = 32'($urandom_range(0, 200)) - 32'd100;
         r = md_model(d, a, b);
         run_op(d, a, b, 5'(k + 20), r[31:0], r[32], lat);
      end

      sb.push_back('{rd: 5'd9, exc: 1'b0, data: 32'd14});
      do_req(1, 32'd100, 32'd7, 5'd9);
      wb_ready = 1'b0;
      for (int i = 0; i < 100 && !wb_valid; i++) @(negedge clock);
      check("stall_valid", wb_valid, 1);
      req_valid = 1'b1; req_is_div = 1'b0; req_opA = 32'h11; req_opB = 32'h22; req_rd = 5'd30;
      m0 = n_mul + n_div;
      repeat (5) begin
         @(negedge clock);
         check("stall_data", wb_data, 32'd14);
         check("stall_rd", wb_rd, 9);
         check("stall_exc", wb_exception, 0);
         check("stall_ready", req_ready, 0);
      end
      req_valid = 1'b0;
      wb_ready = 1'b1;
      wait_wb(lat);
      check("stall_no_issue", n_mul + n_div - m0, 0);
      check("ready_after_hs", req_ready, 1);

      do_req(0, 32'd123, 32'd456, 5'd17);
      repeat (5) @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      check("arst_req_ready", req_ready, 1);
      check("arst_wb_valid", wb_valid, 0);
      check("arst_wb_data", wb_data, 0);
      check("arst_wb_rd", wb_rd, 0);
      check("arst_opA", md_operandA, 0);
      check("arst_ctrl", {md_ctrl_MULT, md_ctrl_DIV}, 0);
      @(negedge clock);
      reset_n = 1'b1;
      cnt = 0;
      repeat (40) begin
         @(negedge clock);
         if (wb_valid || !req_ready) cnt++;
      end
      check("stray_rdy_ignored", cnt, 0);

      do_req(0, 32'd9, 32'd9, 5'd3);
      repeat (10) @(negedge clock);
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      cnt = 0;
      for (int i = 0; i < 100 && !md_resultRDY; i++) begin
         if (wb_valid) cnt++;
         @(negedge clock);
      end
      check("drain_rdy_seen", md_resultRDY, 1);
      check("drain_busy", req_ready, 0);
      @(negedge clock);
      check("drain_idle", req_ready, 1);
      check("drain_no_wb", cnt, 0);
      m0 = n_mul;
      run_op(0, 32'd3, 32'd4, 5'd4, 32'd12, 1'b0, lat);
      check("post_flush_pulse", n_mul - m0, 1);

      stub_dead = 1'b1;
      run_op(0, 32'd2, 32'd3, 5'd7, 32'h0, 1'b1, lat);
      check("timeout_latency", lat, TO + 1);
      stub_dead = 1'b0;

      check("ctrl_consec", n_consec, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
